// File: rtl/mobilenet_v1_pkg.sv
// Shared types and default sizing for the MobileNet v1 pointwise parameter path.
// Used by the pointwise scheduler and the parameter cache.
package mobilenet_v1_pkg;

    localparam int DEFAULT_DIM_W    = 16;
    localparam int DEFAULT_PW_GROUP = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REQ,
        LOAD_WAIT,
        RUN,
        DONE
    } pw_sched_state_t;

endpackage

// File: rtl/mobilenet_v1_pw_idx_counter.sv
// Nested input-channel / group-local output-channel counter for the pointwise scheduler.
// Flags the last beat of an output channel, of a group and of the whole layer.
module mobilenet_v1_pw_idx_counter
    import mobilenet_v1_pkg::*;
#(
    parameter int DIM_W    = DEFAULT_DIM_W,
    parameter int PW_GROUP = DEFAULT_PW_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] in_c,
    input  logic [DIM_W-1:0] out_c,
    input  logic [DIM_W-1:0] group_base,
    output logic [DIM_W-1:0] in_idx,
    output logic [DIM_W-1:0] out_idx,
    output logic             in_wrap,
    output logic             group_end,
    output logic             layer_end
);

    localparam logic [DIM_W-1:0] ONE        = DIM_W'(1);
    localparam logic [DIM_W-1:0] LOCAL_LAST = DIM_W'(PW_GROUP - 1);

    logic [DIM_W-1:0] in_q;
    logic [DIM_W-1:0] local_q;
    logic             out_last;

    assign in_idx    = in_q;
    assign out_idx   = group_base + local_q;
    assign out_last  = (out_idx == out_c - ONE);
    assign in_wrap   = (in_q == in_c - ONE);
    assign group_end = in_wrap && ((local_q == LOCAL_LAST) || out_last);
    assign layer_end = in_wrap && out_last;

    // A group-end wrap returns local to 0 so the next group starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            local_q <= '0;
        end else if (clear) begin
            in_q    <= '0;
            local_q <= '0;
        end else if (advance) begin
            if (in_wrap) begin
                in_q    <= '0;
                local_q <= group_end ? '0 : local_q + ONE;
            end else begin
                in_q <= in_q + ONE;
            end
        end
    end

endmodule

// File: rtl/mobilenet_v1_pw_sched.sv
// Pointwise-layer sequencer: requests cached weight groups and steps channel indices to the PW MAC.
// Optional perf counters are enabled with MOBILENET_PW_SCHED_PERF_EN.
module mobilenet_v1_pw_sched
    import mobilenet_v1_pkg::*;
#(
    parameter int DIM_W    = DEFAULT_DIM_W,
    parameter int PW_GROUP = DEFAULT_PW_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] layer_in_c,
    input  logic [DIM_W-1:0] layer_out_c,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             pw_group_req,
    output logic [DIM_W-1:0] pw_group_idx,
    input  logic             pw_group_ready,
    output logic [DIM_W-1:0] pw_in_ch_idx,
    output logic [DIM_W-1:0] pw_out_ch_idx,
    output logic             mac_valid,
    input  logic             mac_ready,
    output logic             mac_last
`ifdef MOBILENET_PW_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_load_cycles,
    output logic [31:0]      perf_stall_cycles
`endif
);

    localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);
    localparam logic [DIM_W-1:0] GROUP_W = DIM_W'(PW_GROUP);

    pw_sched_state_t  state_q, state_d;
    logic [DIM_W-1:0] in_c_q, out_c_q, group_q, group_base;
    logic             error_q, wait_seen_q;
    logic             start_ok, dims_zero, handshake;
    logic             in_wrap, group_end, layer_end;

    assign start_ok   = (state_q == IDLE) && start;
    assign dims_zero  = (layer_in_c == '0) || (layer_out_c == '0);
    assign handshake  = (state_q == RUN) && mac_ready;
    assign group_base = group_q * GROUP_W;

    mobilenet_v1_pw_idx_counter #(
        .DIM_W    (DIM_W),
        .PW_GROUP (PW_GROUP)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok && !dims_zero),
        .advance    (handshake),
        .in_c       (in_c_q),
        .out_c      (out_c_q),
        .group_base (group_base),
        .in_idx     (pw_in_ch_idx),
        .out_idx    (pw_out_ch_idx),
        .in_wrap    (in_wrap),
        .group_end  (group_end),
        .layer_end  (layer_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_c_q      <= '0;
            out_c_q     <= '0;
            group_q     <= '0;
            error_q     <= 1'b0;
            wait_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_seen_q <= (state_q == LOAD_WAIT);
            if (start_ok) begin
                error_q <= dims_zero;
                group_q <= '0;
                if (!dims_zero) begin
                    in_c_q  <= layer_in_c;
                    out_c_q <= layer_out_c;
                end
            end else if (handshake && group_end && !layer_end) begin
                group_q <= group_q + ONE;
            end else if (state_q == DONE) begin
                group_q <= '0;
            end
        end
    end

    // The first LOAD_WAIT cycle ignores ready so a level left over from the previous group cannot leak through.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = dims_zero ? DONE : LOAD_REQ;
            LOAD_REQ:  state_d = LOAD_WAIT;
            LOAD_WAIT: if (wait_seen_q && pw_group_ready) state_d = RUN;
            RUN:       if (handshake && group_end) state_d = layer_end ? DONE : LOAD_REQ;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign error        = error_q;
    assign pw_group_req = (state_q == LOAD_REQ);
    assign pw_group_idx = group_q;
    assign mac_valid    = (state_q == RUN);
    assign mac_last     = mac_valid && in_wrap;

`ifdef MOBILENET_PW_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (start_ok) begin
            perf_load_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (((state_q == LOAD_REQ) || (state_q == LOAD_WAIT)) && (perf_load_cycles != '1))
                perf_load_cycles <= perf_load_cycles + 32'd1;
            if ((state_q == RUN) && !mac_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mobilenet_v1_pw_sched.md
Name: mobilenet_v1_pw_sched

Overview:
Sequencer for pointwise-layer parameter traffic through mobilenet_v1_param_cache. For each PW layer it splits output channels into groups of PW_GROUP and requests each group load with a pw_group_req pulse. After pw_group_ready, it steps pw_in_ch_idx/pw_out_ch_idx across the group, using a valid/ready handshake to the PW MAC engine. It sits between the layer controller (start/done) and the cache/PE pair.

Parameters:
DIM_W, 16, width of channel counts and indices
PW_GROUP, 8, output channels per cached group (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  layer start pulse; accepted only in IDLE
layer_in_c  in  DIM_W  PW input channels; latched on accepted start
layer_out_c  in  DIM_W  PW output channels; latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of layer
error  out  1  sticky; zero channel count seen at start; cleared by next accepted start
pw_group_req  out  1  one-cycle group-load request to cache
pw_group_idx  out  DIM_W  group being loaded/consumed
pw_group_ready  in  1  cache level: group resident
pw_in_ch_idx  out  DIM_W  input channel index to cache/PE
pw_out_ch_idx  out  DIM_W  global output channel = pw_group_idx*PW_GROUP + local
mac_valid  out  1  indices valid for PE
mac_ready  in  1  PE accepts current indices
mac_last  out  1  current beat is last input channel of this output channel (accumulator flush)

Behaviour:
- Clock and reset: one clock clk. rst_n is asynchronous, active-low.
- Reset: state IDLE; every output 0; latched dims 0.
- IDLE -> start=1:
  - If either dim is 0: error=1, go to DONE, no pw_group_req.
  - Otherwise: latch dims, clear error, group=0, local=0, in=0, go to LOAD_REQ.
- LOAD_REQ: pw_group_req=1 for exactly this cycle (Moore output; first req one cycle after start). Next state LOAD_WAIT.
- LOAD_WAIT: pw_group_ready is ignored in the first LOAD_WAIT cycle (guard against stale ready). From the second cycle on, ready=1 moves to RUN. There is no timeout in the base build.
- RUN:
  - mac_valid=1. Indices and mac_last hold while mac_ready=0.
  - On valid&ready: in++.
  - When in==in_c-1: in=0 and local++.
  - The group ends when local==PW_GROUP-1 or the global out index==out_c-1.
  - At group end: if this is the last group go to DONE, else group++, local=0, go to LOAD_REQ.
  - mac_valid drops in the cycle after the final handshake of a group.
- mac_last = mac_valid && in==in_c-1.
- Group count = ceil(out_c/PW_GROUP); the last group may be partial.
- Handshakes per layer = in_c*out_c exactly; req pulses = group count exactly.
- DONE: done=1 for one cycle, busy=1, then IDLE. pw_group_idx/indices return to 0 in IDLE.
- start while busy is ignored.
- Counter arithmetic is DIM_W unsigned; the product group*PW_GROUP is truncated to DIM_W (caller keeps out_c < 2^DIM_W).
- Reset asserted mid-operation: immediate IDLE; no done pulse; no req.

Optional Feature:
Macro MOBILENET_PW_SCHED_PERF_EN.
- With it: adds outputs perf_load_cycles and perf_stall_cycles (32 bits each, saturating).
  - perf_load_cycles counts LOAD_REQ+LOAD_WAIT cycles.
  - perf_stall_cycles counts RUN cycles with mac_ready=0.
  - Both clear on accepted start and hold after done.
- Without it: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mobilenet_v1_pkg holds:
  - the pw_sched_state_t enum {IDLE, LOAD_REQ, LOAD_WAIT, RUN, DONE};
  - the default DIM_W and PW_GROUP localparams shared with the param cache.
- One sub-module, mobilenet_v1_pw_idx_counter, is natural. It holds the nested in/local counter with an advance input and wrap/group_end/last outputs.

Test Plan:
- in_c=3, out_c=8, PW_GROUP=4, mac_ready=1, ready 2 cycles after req -> 2 req pulses (idx 0,1), 24 handshakes, out idx 0..7, 8 mac_last, one done, error=0.
- out_c=10, in_c=2, PW_GROUP=4 -> 3 groups; group 2 covers out 8,9 only; 20 handshakes; done after out 9/in 1.
- Backpressure: mac_ready random 50% -> indices/mac_last stable while ready=0; handshake sequence identical to the ready=1 case.
- pw_group_ready held high from before req (stale) -> no mac_valid before 2nd LOAD_WAIT cycle; ready delayed 5 cycles -> mac_valid exactly 1 cycle after ready seen.
- start with layer_in_c=0 -> error=1, done pulse, no pw_group_req, no mac_valid. Next valid start clears error. start while busy is ignored.
- rst_n low during RUN of group 1 -> all outputs 0 asynchronously; after release, fresh start runs a full layer correctly.
